// File: rtl/axi_rd_burst_sched_phase2.sv
// Phase-2 AXI read-burst scheduler: splits 16 equal-size streams into AR bursts, round-robin with credit gating.
// Optional per-stream AR handshake counters are enabled by defining RD_BURST_CNT_EN.
`timescale 1ns/1ps
module axi_rd_burst_sched_phase2 #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 64,
  parameter int C_NUM_STREAMS      = 16,
  parameter int C_DATA_BYTES       = 64,
  parameter int C_BURST_LEN        = 64,
  parameter int C_ID_WIDTH         = 4
) (
  input  logic                                             aclk,
  input  logic                                             areset,
  input  logic                                             i_start,
  input  logic [C_NUM_STREAMS-1:0][C_M_AXI_ADDR_WIDTH-1:0] i_read_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0]                     i_read_size_in_bytes,
  input  logic [C_NUM_STREAMS-1:0]                         i_credit,
  output logic                                             m_axi_arvalid,
  input  logic                                             m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]                    m_axi_araddr,
  output logic [7:0]                                       m_axi_arlen,
  output logic [C_ID_WIDTH-1:0]                            m_axi_arid,
  output logic                                             o_busy,
  output logic                                             o_done
`ifdef RD_BURST_CNT_EN
  ,output logic [C_NUM_STREAMS-1:0][15:0]                  o_burst_cnt
`endif
);

  localparam logic [C_XFER_SIZE_WIDTH-1:0] BURST_BYTES = C_XFER_SIZE_WIDTH'(C_BURST_LEN * C_DATA_BYTES);
  localparam logic [C_XFER_SIZE_WIDTH-1:0] BEAT_MASK   = C_XFER_SIZE_WIDTH'(C_DATA_BYTES - 1);
  localparam int                           DB_LOG      = $clog2(C_DATA_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARB, S_ISSUE, S_DONE} state_t;

  state_t state_q, state_d;

  logic [C_NUM_STREAMS-1:0][C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [C_NUM_STREAMS-1:0][C_XFER_SIZE_WIDTH-1:0]  rem_q;
  logic [C_ID_WIDTH-1:0]                            rr_q;
  logic                                             arvalid_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0]                    araddr_q;
  logic [7:0]                                       arlen_q;
  logic [C_ID_WIDTH-1:0]                            arid_q;
  logic [C_XFER_SIZE_WIDTH-1:0]                     bytes_q;
  logic                                             busy_q;
  logic                                             done_q;

  logic                         found;
  logic                         all_zero;
  logic [C_ID_WIDTH-1:0]        idx;
  logic [C_ID_WIDTH-1:0]        sel;
  logic [C_XFER_SIZE_WIDTH-1:0] sel_rem;
  logic [C_XFER_SIZE_WIDTH-1:0] sel_bytes;
  logic [7:0]                   sel_len;
  logic                         start_acc;
  logic                         hs;

  assign start_acc = (state_q == S_IDLE) && i_start;
  // arvalid is always high while in ISSUE, so arready alone completes the handshake
  assign hs        = (state_q == S_ISSUE) && m_axi_arready;

  always_comb begin
    found    = 1'b0;
    all_zero = 1'b1;
    idx      = rr_q;
    sel      = rr_q;
    for (int i = 0; i < C_NUM_STREAMS; i++) begin
      idx = rr_q + C_ID_WIDTH'(i);
      if (rem_q[i] != '0) all_zero = 1'b0;
      if (!found && (rem_q[idx] != '0) && i_credit[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    sel_rem = rem_q[sel];
    // tail bursts round up to whole beats; the remaining count saturates on subtraction
    if (sel_rem >= BURST_BYTES) begin
      sel_len   = 8'(C_BURST_LEN - 1);
      sel_bytes = BURST_BYTES;
    end else begin
      sel_len   = 8'(((sel_rem + BEAT_MASK) >> DB_LOG) - C_XFER_SIZE_WIDTH'(1));
      sel_bytes = (sel_rem + BEAT_MASK) & ~BEAT_MASK;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_LOAD;
      S_LOAD:  state_d = all_zero ? S_DONE : S_ARB;
      S_ARB: begin
        if (all_zero)   state_d = S_DONE;
        else if (found) state_d = S_ISSUE;
      end
      S_ISSUE: if (hs) state_d = S_ARB;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      addr_q    <= '0;
      rem_q     <= '0;
      rr_q      <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arid_q    <= '0;
      bytes_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      if (start_acc) begin
        addr_q <= i_read_addr;
        for (int s = 0; s < C_NUM_STREAMS; s++) rem_q[s] <= i_read_size_in_bytes;
        busy_q <= 1'b1;
      end else if (state_q == S_DONE) begin
        busy_q <= 1'b0;
      end
      if ((state_q == S_ARB) && !all_zero && found) begin
        arvalid_q <= 1'b1;
        araddr_q  <= addr_q[sel];
        arlen_q   <= sel_len;
        arid_q    <= sel;
        bytes_q   <= sel_bytes;
      end
      if (hs) begin
        arvalid_q      <= 1'b0;
        addr_q[arid_q] <= addr_q[arid_q] + C_M_AXI_ADDR_WIDTH'(bytes_q);
        rem_q[arid_q]  <= (rem_q[arid_q] > bytes_q) ? (rem_q[arid_q] - bytes_q) : '0;
        rr_q           <= arid_q + C_ID_WIDTH'(1);
      end
    end
  end

`ifdef RD_BURST_CNT_EN
  logic [C_NUM_STREAMS-1:0][15:0] cnt_q;

  always_ff @(posedge aclk) begin
    if (areset || start_acc) cnt_q <= '0;
    else if (hs)             cnt_q[arid_q] <= cnt_q[arid_q] + 16'd1;
  end

  assign o_burst_cnt = cnt_q;
`endif

  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arid    = arid_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_axi_rd_burst_sched_phase2.sv
// Directed bench for axi_rd_burst_sched_phase2; build with RD_BURST_CNT_EN defined to cover the counters.
`timescale 1ns/1ps
module tb_axi_rd_burst_sched_phase2;

  logic              aclk = 1'b0;
  logic              areset;
  logic              i_start;
  logic [15:0][63:0] i_read_addr;
  logic [63:0]       i_read_size_in_bytes;
  logic [15:0]       i_credit;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [63:0]       m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [3:0]        m_axi_arid;
  logic              o_busy;
  logic              o_done;
`ifdef RD_BURST_CNT_EN
  logic [15:0][15:0] o_burst_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [3:0]  q_id[$];
  logic [7:0]  q_len[$];
  logic [63:0] q_addr[$];

  always #5 aclk = ~aclk;

  axi_rd_burst_sched_phase2 dut (
    .aclk                 (aclk),
    .areset               (areset),
    .i_start              (i_start),
    .i_read_addr          (i_read_addr),
    .i_read_size_in_bytes (i_read_size_in_bytes),
    .i_credit             (i_credit),
    .m_axi_arvalid        (m_axi_arvalid),
    .m_axi_arready        (m_axi_arready),
    .m_axi_araddr         (m_axi_araddr),
    .m_axi_arlen          (m_axi_arlen),
    .m_axi_arid           (m_axi_arid),
    .o_busy               (o_busy),
    .o_done               (o_done)
`ifdef RD_BURST_CNT_EN
    ,.o_burst_cnt         (o_burst_cnt)
`endif
  );

  // handshake recorder; inputs change just after posedge, so negedge is quiet
  always @(negedge aclk) begin
    if (!areset && m_axi_arvalid && m_axi_arready) begin
      q_id.push_back(m_axi_arid);
      q_len.push_back(m_axi_arlen);
      q_addr.push_back(m_axi_araddr);
    end
    if (o_done) done_cnt++;
  end

  function automatic logic [63:0] base(input int s);
    return 64'h1_0000_0000 + 64'(s) * 64'h1_0000;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_addrs();
    for (int s = 0; s < 16; s++) i_read_addr[s] = base(s);
  endtask

  task automatic clear_log();
    q_id.delete();
    q_len.delete();
    q_addr.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [63:0] size);
    @(posedge aclk); #1;
    i_read_size_in_bytes = size;
    i_start = 1'b1;
    @(posedge aclk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge aclk);
    while (o_done !== 1'b1 && n < budget) begin
      @(negedge aclk);
      n++;
    end
    chk({tag, "_done"}, 128'(o_done), 128'(1));
    chk({tag, "_busy_at_done"}, 128'(o_busy), 128'(0));
    @(negedge aclk);
    chk({tag, "_done_one_cycle"}, 128'(o_done), 128'(0));
  endtask

  initial begin
    int n;
    int s;
    int r;
    areset = 1'b1;
    i_start = 1'b0;
    i_read_size_in_bytes = '0;
    i_credit = '0;
    m_axi_arready = 1'b0;
    set_addrs();
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_arvalid", 128'(m_axi_arvalid), 128'(0));
    chk("rst_araddr", 128'(m_axi_araddr), 128'(0));
    chk("rst_arlen", 128'(m_axi_arlen), 128'(0));
    chk("rst_arid", 128'(m_axi_arid), 128'(0));
    chk("rst_busy", 128'(o_busy), 128'(0));
    chk("rst_done", 128'(o_done), 128'(0));
`ifdef RD_BURST_CNT_EN
    chk("rst_cnt", 128'(o_burst_cnt), 128'(0));
`endif
    areset = 1'b0;

    // single full burst per stream
    clear_log();
    i_credit = '1;
    m_axi_arready = 1'b1;
    do_start(64'd4096);
    chk("t1_busy", 128'(o_busy), 128'(1));
    chk("t1_lat1", 128'(m_axi_arvalid), 128'(0));
    @(posedge aclk); #1;
    chk("t1_lat2", 128'(m_axi_arvalid), 128'(0));
    @(posedge aclk); #1;
    chk("t1_lat3", {m_axi_arvalid, m_axi_arid}, {1'b1, 4'd0});
    wait_done("t1", 200);
    chk("t1_count", 128'(q_id.size()), 128'(16));
    for (int i = 0; i < 16; i++)
      chk("t1_burst", {q_id[i], q_len[i], q_addr[i]}, {4'(i), 8'd63, base(i)});
    chk("t1_done_pulses", 128'(done_cnt), 128'(1));

    // 9216 bytes: 4096 + 4096 + 1024 per stream
    clear_log();
    do_start(64'd9216);
    wait_done("t2", 400);
    chk("t2_count", 128'(q_id.size()), 128'(48));
    for (int i = 0; i < 48; i++) begin
      s = i % 16;
      r = i / 16;
      chk("t2_burst", {q_id[i], q_len[i], q_addr[i]},
          {4'(s), (r < 2) ? 8'd63 : 8'd15, base(s) + 64'(r) * 64'd4096});
    end
    chk("t2_done_pulses", 128'(done_cnt), 128'(1));
`ifdef RD_BURST_CNT_EN
    for (int i = 0; i < 16; i++) chk("t2_cnt", 128'(o_burst_cnt[i]), 128'(3));
`endif

    // zero size: done three edges after start, no AR traffic
    clear_log();
    do_start(64'd0);
    chk("t3_busy", {o_busy, o_done}, {1'b1, 1'b0});
`ifdef RD_BURST_CNT_EN
    chk("t3_cnt_clear", 128'(o_burst_cnt), 128'(0));
`endif
    @(posedge aclk); #1;
    chk("t3_n2", {o_busy, o_done, m_axi_arvalid}, {1'b1, 1'b0, 1'b0});
    @(posedge aclk); #1;
    chk("t3_n3", {o_busy, o_done}, {1'b0, 1'b1});
    @(posedge aclk); #1;
    chk("t3_n4", 128'(o_done), 128'(0));
    chk("t3_no_ar", 128'(q_id.size()), 128'(0));

    // stream 5 without credit is skipped until credit returns
    clear_log();
    i_credit = 16'hFFDF;
    do_start(64'd4096);
    repeat (60) @(posedge aclk);
    #1;
    chk("t4_stalled_count", 128'(q_id.size()), 128'(15));
    chk("t4_stalled", {o_busy, m_axi_arvalid}, {1'b1, 1'b0});
    i_credit = '1;
    wait_done("t4", 50);
    chk("t4_count", 128'(q_id.size()), 128'(16));
    for (int i = 0; i < 16; i++) begin
      s = (i < 5) ? i : ((i < 15) ? i + 1 : 5);
      chk("t4_order", {q_id[i], q_addr[i]}, {4'(s), base(s)});
    end

    // backpressure; RR pointer sits at 6 after stream 5 went last
    clear_log();
    m_axi_arready = 1'b0;
    do_start(64'd4096);
    n = 0;
    while (m_axi_arvalid !== 1'b1 && n < 10) begin
      @(posedge aclk); #1;
      n++;
    end
    chk("t5_first", {m_axi_arvalid, m_axi_arid, m_axi_arlen, m_axi_araddr}, {1'b1, 4'd6, 8'd63, base(6)});
    for (int i = 0; i < 16; i++) i_read_addr[i] = '0;
    i_read_size_in_bytes = '0;
    i_start = 1'b1;
    @(posedge aclk); #1;
    i_start = 1'b0;
    set_addrs();
    i_read_size_in_bytes = 64'd4096;
    chk("t5_busy", 128'(o_busy), 128'(1));
    for (int i = 0; i < 10; i++) begin
      chk("t5_hold", {m_axi_arvalid, m_axi_arid, m_axi_arlen, m_axi_araddr}, {1'b1, 4'd6, 8'd63, base(6)});
      @(posedge aclk); #1;
    end
    m_axi_arready = 1'b1;
    @(posedge aclk); #1;
    m_axi_arready = 1'b0;
    chk("t5_drop", 128'(m_axi_arvalid), 128'(0));
    @(posedge aclk); #1;
    chk("t5_next", {m_axi_arvalid, m_axi_arid, m_axi_arlen, m_axi_araddr}, {1'b1, 4'd7, 8'd63, base(7)});
    areset = 1'b1;
    @(posedge aclk); #1;
    chk("t5_reset", {m_axi_arvalid, m_axi_arid, m_axi_arlen, m_axi_araddr, o_busy, o_done}, 128'(0));
    areset = 1'b0;
    chk("t5_hs", 128'(q_id.size()), 128'(1));

    // after a mid-run reset the pointer restarts at stream 0
    clear_log();
    m_axi_arready = 1'b1;
    do_start(64'd4096);
    wait_done("t6", 200);
    chk("t6_count", 128'(q_id.size()), 128'(16));
    chk("t6_first", {q_id[0], q_addr[0]}, {4'd0, base(0)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
